// File: rtl/score_keeper.sv
// Tetris scoring stage: accumulates line-clear points into a saturating 16-bit
// score and keeps a registered five-digit BCD copy via iterative double-dabble.
module score_keeper #(
  parameter int unsigned SCORE_MAX = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_valid,
  input  logic [2:0]  lines_cleared,
  input  logic [3:0]  level,
  input  logic        game_over,
  output logic [15:0] player_score,
  output logic [19:0] score_bcd,
  output logic        bcd_valid
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  localparam logic [16:0] MAX17 = 17'(SCORE_MAX);

  logic [15:0] score_q, score_d;
  logic        changed_q, changed_d;
  state_t      state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [19:0] scratch_q, scratch_d;
  logic [19:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;

  logic [13:0] base;
  logic [13:0] incr;
  logic [16:0] sum;
  logic [15:0] clamped;
  logic        accept;

  always_comb begin
    base   = '0;
    accept = 1'b0;
    case (lines_cleared)
      3'd1: base = 14'd100;
      3'd2: base = 14'd300;
      3'd3: base = 14'd500;
      3'd4: base = 14'd800;
      default: base = '0;
    endcase
    if (clear_valid && !game_over && (lines_cleared >= 3'd1) && (lines_cleared <= 3'd4))
      accept = 1'b1;
    incr    = base * (14'(level) + 14'd1);
    sum     = {1'b0, score_q} + {3'b000, incr};
    clamped = (sum > MAX17) ? MAX17[15:0] : sum[15:0];
    score_d   = accept ? clamped : score_q;
    changed_d = accept && (clamped != score_q);
  end

  logic [19:0] adj;
  logic [35:0] shifted;

  always_comb begin
    adj = scratch_q;
    for (int unsigned i = 0; i < 5; i++) begin
      if (scratch_q[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
    end
    shifted = {adj, sr_q} << 1;
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE: begin
        if (changed_q)
          state_d = LOAD;
      end
      LOAD: begin
        sr_d      = score_q;
        scratch_d = '0;
        cnt_d     = '0;
        valid_d   = 1'b0;
        state_d   = changed_q ? LOAD : SHIFT;
      end
      SHIFT: begin
        // A fresh score change aborts this pass; the old result is never published.
        if (changed_q) begin
          state_d = LOAD;
        end else begin
          scratch_d = shifted[35:16];
          sr_d      = shifted[15:0];
          cnt_d     = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            bcd_d   = shifted[35:16];
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      score_q   <= '0;
      changed_q <= 1'b0;
      state_q   <= IDLE;
      sr_q      <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b1;
    end else begin
      score_q   <= score_d;
      changed_q <= changed_d;
      state_q   <= state_d;
      sr_q      <= sr_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
    end
  end

  assign player_score = score_q;
  assign score_bcd    = bcd_q;
  assign bcd_valid    = valid_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: randomized and directed line-clear
// events compared against an arithmetic score model and decimal-digit BCD model.
module tb_score_keeper;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear_valid;
  logic [2:0]  lines_cleared;
  logic [3:0]  level;
  logic        game_over;
  logic [15:0] player_score;
  logic [19:0] score_bcd;
  logic        bcd_valid;

  int checks = 0;
  int errors = 0;
  int model  = 0;
  localparam int MAXV = 65535;

  always #5 clock = ~clock;

  score_keeper #(.SCORE_MAX(MAXV)) dut (
    .clock        (clock),
    .reset        (reset),
    .clear_valid  (clear_valid),
    .lines_cleared(lines_cleared),
    .level        (level),
    .game_over    (game_over),
    .player_score (player_score),
    .score_bcd    (score_bcd),
    .bcd_valid    (bcd_valid)
  );

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int div;
    r = '0;
    div = 1;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'((v / div) % 10);
      div = div * 10;
    end
    return r;
  endfunction

  function automatic int points(input int l);
    case (l)
      1: return 100;
      2: return 300;
      3: return 500;
      4: return 800;
      default: return 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int l, input int lv, input bit go, output bit chg);
    int old;
    old = model;
    lines_cleared = 3'(l);
    level = 4'(lv);
    game_over = go;
    clear_valid = 1'b1;
    tick();
    clear_valid = 1'b0;
    if (l >= 1 && l <= 4 && !go) begin
      model = model + points(l) * (lv + 1);
      if (model > MAXV) model = MAXV;
    end
    chg = (model != old);
    checks++;
    if (player_score !== 16'(model)) begin
      errors++;
      $display("FAIL score l=%0d lv=%0d go=%0b: got %0d expected %0d", l, lv, go, player_score, model);
    end
  endtask

  // already = edges elapsed since the last score-changing strobe
  task automatic expect_conversion(input string name, input int already, input logic [19:0] forbidden);
    bit low_ok;
    bit stale;
    low_ok = 1'b1;
    stale  = 1'b0;
    for (int k = already + 1; k <= 18; k++) begin
      tick();
      if (k >= 2 && k <= 17 && bcd_valid !== 1'b0) low_ok = 1'b0;
      if (bcd_valid === 1'b1 && score_bcd === forbidden) stale = 1'b1;
    end
    checks++;
    if (!low_ok) begin
      errors++;
      $display("FAIL %s valid_low: bcd_valid not held low during conversion, expected 0", name);
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL %s stale: bcd_valid rose with %h, expected never", name, forbidden);
    end
    checks++;
    if (bcd_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s valid_done: got %b expected 1", name, bcd_valid);
    end
    checks++;
    if (score_bcd !== to_bcd(model)) begin
      errors++;
      $display("FAIL %s bcd: got %h expected %h", name, score_bcd, to_bcd(model));
    end
  endtask

  task automatic expect_idle(input string name, input int n);
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      if (bcd_valid !== 1'b1 || score_bcd !== to_bcd(model)) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s idle: got valid=%b bcd=%h expected valid=1 bcd=%h", name, bcd_valid, score_bcd, to_bcd(model));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_valid = 1'b0;
    game_over = 1'b0;
    lines_cleared = '0;
    level = '0;
    tick();
    tick();
    reset = 1'b0;
    model = 0;
    checks++;
    if (player_score !== 16'd0 || score_bcd !== 20'h00000 || bcd_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset: got score=%0d bcd=%h valid=%b expected 0/00000/1", player_score, score_bcd, bcd_valid);
    end
  endtask

  task automatic test_single();
    bit c;
    send(1, 0, 1'b0, c);
    expect_conversion("single", 0, 20'hFFFFF);
    checks++;
    if (score_bcd !== 20'h00100) begin
      errors++;
      $display("FAIL single_const: got %h expected 00100", score_bcd);
    end
  endtask

  task automatic test_tetris_l15();
    bit c;
    test_reset();
    send(4, 15, 1'b0, c);
    expect_conversion("tetris15", 0, 20'hFFFFF);
  endtask

  task automatic test_back_to_back();
    bit c;
    test_reset();
    for (int i = 0; i < 5; i++) send(4, 15, 1'b0, c);
    expect_conversion("b2b_64000", 0, 20'hFFFFF);
    checks++;
    if (score_bcd !== 20'h64000) begin
      errors++;
      $display("FAIL sat_64000: got %h expected 64000", score_bcd);
    end
    send(4, 15, 1'b0, c);
    expect_conversion("sat_65535", 0, 20'hFFFFF);
    checks++;
    if (score_bcd !== 20'h65535 || player_score !== 16'd65535) begin
      errors++;
      $display("FAIL sat_65535: got %0d/%h expected 65535/65535", player_score, score_bcd);
    end
    send(4, 15, 1'b0, c);
    expect_idle("sat_nochange", 20);
  endtask

  task automatic test_illegal();
    bit c;
    test_reset();
    send(2, 3, 1'b0, c);
    expect_conversion("illegal_setup", 0, 20'hFFFFF);
    send(0, 5, 1'b0, c);
    send(5, 2, 1'b0, c);
    send(7, 9, 1'b0, c);
    send(6, 0, 1'b0, c);
    expect_idle("illegal_lines", 20);
    for (int l = 1; l <= 4; l++) send(l, l * 3, 1'b1, c);
    game_over = 1'b0;
    expect_idle("game_over_block", 20);
    send(1, 0, 1'b0, c);
    expect_conversion("game_over_resume", 0, 20'hFFFFF);
  endtask

  task automatic test_restart();
    bit c;
    test_reset();
    send(2, 0, 1'b0, c);
    for (int k = 0; k < 4; k++) tick();
    send(1, 1, 1'b0, c);
    expect_conversion("restart", 0, 20'h00300);
    checks++;
    if (score_bcd !== 20'h00500) begin
      errors++;
      $display("FAIL restart_const: got %h expected 00500", score_bcd);
    end
  endtask

  task automatic test_reset_shift();
    bit c;
    test_reset();
    send(3, 4, 1'b0, c);
    for (int k = 0; k < 8; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model = 0;
    checks++;
    if (player_score !== 16'd0 || score_bcd !== 20'h00000 || bcd_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_shift: got score=%0d bcd=%h valid=%b expected 0/00000/1", player_score, score_bcd, bcd_valid);
    end
    send(3, 0, 1'b0, c);
    expect_conversion("after_reset", 0, 20'hFFFFF);
  endtask

  task automatic test_random();
    bit c;
    bit any;
    int since;
    int burst;
    test_reset();
    for (int it = 0; it < 40; it++) begin
      if (it % 10 == 9) test_reset();
      any = 1'b0;
      since = 0;
      burst = $urandom_range(1, 3);
      for (int b = 0; b < burst; b++) begin
        send($urandom_range(0, 7), $urandom_range(0, 15), ($urandom_range(0, 7) == 0), c);
        if (c) begin
          any = 1'b1;
          since = 0;
        end else begin
          since++;
        end
      end
      game_over = 1'b0;
      if (any) expect_conversion("random", since, 20'hFFFFF);
      else expect_idle("random_idle", 20);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tetris_l15();
    test_back_to_back();
    test_illegal();
    test_restart();
    test_reset_shift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
